// File: rtl/sd_pkg.sv
// Shared SD host definitions: response lengths, CRC7 polynomial, receiver states.
package sd_pkg;

    localparam int SD_RESP_SHORT_LEN = 48;
    localparam int SD_RESP_LONG_LEN  = 136;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECV,
        DONE
    } rx_state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first input, zero initial value.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & SD_CRC7_POLY);
        end
    end

endmodule

// File: rtl/sd_cmd_rx.sv
// SD CMD-line response receiver (48-bit and 136-bit R2 frames).
// Define SD_CMD_RX_CRC_EN to build the CRC7 checker; otherwise crc_err is tied 0.
module sd_cmd_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         long_resp,
    input  logic         sd_cmd,
    output logic         busy,
    output logic         done,
    output logic [135:0] resp,
    output logic         crc_err,
    output logic         end_err,
    output logic         timeout
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    rx_state_t      state, next_state;
    logic           len_sel;
    logic           to_pend;
    logic [WW-1:0]  wait_cnt;
    logic [7:0]     bit_cnt;
    logic [7:0]     last_idx;
    logic [135:0]   shreg;
    logic           arm;
    logic           crc_mis;

    assign arm      = (state == IDLE) && en;
    assign last_idx = len_sel ? 8'(SD_RESP_LONG_LEN - 1) : 8'(SD_RESP_SHORT_LEN - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (en) next_state = WAIT_START;
            WAIT_START: begin
                if (!sd_cmd) begin
                    next_state = RECV;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = DONE;
                end
            end
            RECV:       if (bit_cnt == last_idx) next_state = DONE;
            DONE:       next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

`ifdef SD_CMD_RX_CRC_EN
    logic       crc_en;
    logic [6:0] crc;

    // Start bit is never fed: a 0 into a zeroed register leaves it at 0,
    // so the short-frame window 47..8 reduces to counts 1..39.
    always_comb begin
        crc_en = 1'b0;
        if (state == RECV) begin
            if (len_sel) begin
                crc_en = (bit_cnt >= 8'd8) && (bit_cnt <= 8'd127);
            end else begin
                crc_en = (bit_cnt <= 8'd39);
            end
        end
    end

    sd_crc7 u_crc7 (
        .clk   (clk),
        .reset (reset),
        .clr   (arm),
        .en    (crc_en),
        .din   (sd_cmd),
        .crc   (crc)
    );

    assign crc_mis = (crc != shreg[7:1]);
`else
    assign crc_mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_sel  <= 1'b0;
            to_pend  <= 1'b0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            resp     <= '0;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        len_sel  <= long_resp;
                        to_pend  <= 1'b0;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        crc_err  <= 1'b0;
                        end_err  <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (!sd_cmd) begin
                        // Clearing the upper bits keeps short frames right-aligned.
                        shreg   <= {135'b0, sd_cmd};
                        bit_cnt <= 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) to_pend <= 1'b1;
                    end
                end
                RECV: begin
                    shreg   <= {shreg[134:0], sd_cmd};
                    bit_cnt <= bit_cnt + 8'd1;
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    timeout <= to_pend;
                    if (!to_pend) begin
                        resp    <= shreg;
                        end_err <= ~shreg[0];
                        crc_err <= crc_mis;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Scoreboard bench for sd_cmd_rx: random frames checked against a polynomial-division CRC model.
module tb_sd_cmd_rx;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         long_resp = 1'b0;
    logic         sd_cmd = 1'b1;
    logic         busy, done, crc_err, end_err, timeout;
    logic [135:0] resp;

    typedef struct {
        logic [135:0] resp;
        logic         crc_err;
        logic         end_err;
        logic         timeout;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [135:0] last_resp = '0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_done = 0;

    always #5 clk = ~clk;

    sd_cmd_rx #(.TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .long_resp (long_resp),
        .sd_cmd    (sd_cmd),
        .busy      (busy),
        .done      (done),
        .resp      (resp),
        .crc_err   (crc_err),
        .end_err   (end_err),
        .timeout   (timeout)
    );

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, M = frame bits hi..lo.
    function automatic logic [6:0] crc_model(input logic [135:0] f, input int hi, input int lo);
        logic [142:0] d;
        d = '0;
        for (int i = hi; i >= lo; i--) d = {d[141:0], f[i]};
        d = d << 7;
        for (int j = 142; j >= 7; j--) if (d[j]) d[j -: 8] = d[j -: 8] ^ 8'h89;
        return d[6:0];
    endfunction

    function automatic logic [135:0] make_frame(input logic [135:0] f, input bit long);
        logic [135:0] g;
        g = f;
        g[7:1] = crc_model(g, long ? 127 : 47, 8);
        g[0] = 1'b1;
        return g;
    endfunction

    function automatic exp_t model(input logic [135:0] f, input bit long);
        exp_t e;
        e.resp    = long ? f : {88'b0, f[47:0]};
        e.end_err = ~f[0];
        e.timeout = 1'b0;
`ifdef SD_CMD_RX_CRC_EN
        e.crc_err = (crc_model(f, long ? 127 : 47, 8) != f[7:1]);
`else
        e.crc_err = 1'b0;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending response");
            end else begin
                mon_e = sb.pop_front();
                check("resp", resp, mon_e.resp);
                check("crc_err", 136'(crc_err), 136'(mon_e.crc_err));
                check("end_err", 136'(end_err), 136'(mon_e.end_err));
                check("timeout", 136'(timeout), 136'(mon_e.timeout));
                check("busy_at_done", 136'(busy), 136'd0);
            end
        end
    end

    task automatic send_frame(input logic [135:0] f, input bit long, input int idle,
                              input int en_mid, input int abort_at);
        int n;
        int lat;
        int d0;
        bit busy_ok;
        exp_t e;
        n = long ? 136 : 48;
        d0 = n_done;
        if (abort_at < 0) begin
            e = model(f, long);
            sb.push_back(e);
        end
        @(negedge clk);
        en = 1'b1;
        long_resp = long;
        @(negedge clk);
        en = 1'b0;
        long_resp = 1'($urandom);
        busy_ok = 1'b1;
        repeat (idle) begin
            if (!busy) busy_ok = 1'b0;
            sd_cmd = 1'b1;
            @(negedge clk);
        end
        for (int i = n - 1; i >= 0; i--) begin
            if (n - 1 - i == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_resp", resp, '0);
                check("abort_flags", 136'({busy, done, crc_err, end_err, timeout}), '0);
                last_resp = '0;
                sd_cmd = 1'b1;
                @(negedge clk);
                reset = 1'b1;
                repeat (3) @(negedge clk);
                check("abort_no_done", 136'(n_done - d0), '0);
                return;
            end
            if (!busy) busy_ok = 1'b0;
            sd_cmd = f[i];
            en = (n - 1 - i == en_mid);
            @(negedge clk);
        end
        en = 1'b0;
        sd_cmd = 1'b1;
        lat = n;
        while (!done && lat < n + 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 136'(lat), 136'(n + 1));
        check("busy_high", 136'(busy_ok), 136'd1);
        repeat (4) @(negedge clk);
        check("single_done", 136'(n_done - d0), 136'd1);
        last_resp = e.resp;
    endtask

    task automatic run_timeout();
        int lat;
        exp_t e;
        e.resp = last_resp;
        e.crc_err = 1'b0;
        e.end_err = 1'b0;
        e.timeout = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        sd_cmd = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_latency", 136'(lat), 136'd66);
        repeat (2) @(negedge clk);
    endtask

    logic [135:0] f;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_resp", resp, '0);
        check("reset_flags", 136'({busy, done, crc_err, end_err, timeout}), '0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        f = 136'h08000001AA13;
        send_frame(f, 1'b0, 5, -1, -1);
        f[20] = ~f[20];
        send_frame(f, 1'b0, 3, -1, -1);
        f = 136'h08000001AA12;
        send_frame(f, 1'b0, 2, -1, -1);
        run_timeout();

        f = make_frame({8'h3F, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        send_frame(f, 1'b1, 3, 60, -1);

        f = '0;
        f[47:0] = {2'b00, 14'($urandom), $urandom};
        send_frame(make_frame(f, 1'b0), 1'b0, 2, -1, 30);
        send_frame(make_frame(f, 1'b0), 1'b0, 4, -1, -1);

        for (int k = 0; k < 8; k++) begin
            bit long;
            int b;
            long = (k % 4 == 3);
            f = '0;
            if (long) f = {8'h3F, $urandom, $urandom, $urandom, $urandom};
            else      f[47:0] = {2'b00, 14'($urandom), $urandom};
            f = make_frame(f, long);
            if ($urandom_range(2) == 0) begin
                b = $urandom_range(long ? 127 : 46);
                f[b] = ~f[b];
            end
            send_frame(f, long, $urandom_range(10), -1, -1);
        end
        run_timeout();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 136'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
